// File: rtl/button_debounce_if.sv
// Button conditioning bus: raw pad input and repeat enable in, debounced level and strobes out.
// Latency: none (wires only).
// Backpressure: none; strobes are single-cycle and are not acknowledged.
//
// Signals
//   button     raw, unsynchronised pad level (1 = pressed)      master -> slave
//   rep_en     auto-repeat enable while held                    master -> slave
//   btn_level  debounced button state                           slave  -> master
//   btn_pulse  one-cycle strobe on accepted press / auto-repeat  slave  -> master
//   btn_rel    one-cycle strobe on accepted release              slave  -> master
interface button_debounce_if;
   logic button;
   logic rep_en;
   logic btn_level;
   logic btn_pulse;
   logic btn_rel;

   modport master (
      output button,
      output rep_en,
      input  btn_level,
      input  btn_pulse,
      input  btn_rel
   );

   modport slave (
      input  button,
      input  rep_en,
      output btn_level,
      output btn_pulse,
      output btn_rel
   );
endinterface

// File: rtl/button_debounce.sv
// Synchronise and debounce a push-button; emit clean level, press/repeat strobe and release strobe.
// Latency: stable input is accepted on the (DEB_CYCLES+3)th clock edge after it is first sampled.
// Backpressure: none; strobes are single-cycle fire-and-forget outputs.
//
// Ports
//   clk   system clock
//   rst   asynchronous reset, active-low
//   bus   button_debounce_if.slave: button, rep_en in; btn_level, btn_pulse, btn_rel out
module button_debounce #(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int REP_DELAY  = 25_000_000,
   parameter int REP_PERIOD = 5_000_000
) (
   input  logic               clk,
   input  logic               rst,
   button_debounce_if.slave   bus
);

   localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
   localparam int CNT_W   = $clog2(DEB_CYCLES);
   localparam int REP_W   = $clog2(REP_MAX);

   localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(DEB_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_DLY_LAST = REP_W'(REP_DELAY - 1);
   localparam logic [REP_W-1:0] REP_PER_LAST = REP_W'(REP_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ARM_PRESS = 2'd1,
      HELD      = 2'd2,
      ARM_REL   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               s1_q, s2_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
   logic               rep_phase_q, rep_phase_d;
   logic               level_q, level_d;
   logic               pulse_q, pulse_d;
   logic               rel_q, rel_d;
   logic [REP_W-1:0]   rep_last;

   // Two-flop synchroniser; s2_q is the only view of the pad the FSM ever uses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= bus.button;
         s2_q <= s1_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
         level_q     <= 1'b0;
         pulse_q     <= 1'b0;
         rel_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         rep_phase_q <= rep_phase_d;
         level_q     <= level_d;
         pulse_q     <= pulse_d;
         rel_q       <= rel_d;
      end
   end

   // First repeat waits REP_DELAY; every later one waits REP_PERIOD.
   assign rep_last = rep_phase_q ? REP_PER_LAST : REP_DLY_LAST;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rep_cnt_d   = rep_cnt_q;
      rep_phase_d = rep_phase_q;
      level_d     = level_q;
      pulse_d     = 1'b0;
      rel_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (s2_q) begin
               state_d = ARM_PRESS;
               cnt_d   = '0;
            end
         end

         ARM_PRESS: begin
            if (!s2_q) begin
               // Bounce: input dropped before the stability window closed.
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = HELD;
               cnt_d       = '0;
               level_d     = 1'b1;
               pulse_d     = 1'b1;
               rep_cnt_d   = '0;
               rep_phase_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         HELD: begin
            if (!s2_q) begin
               // rep_cnt is left frozen so a rejected release glitch does not restart repeat timing.
               state_d = ARM_REL;
               cnt_d   = '0;
            end else if (bus.rep_en) begin
               if (rep_cnt_q == rep_last) begin
                  pulse_d     = 1'b1;
                  rep_cnt_d   = '0;
                  rep_phase_d = 1'b1;
               end else begin
                  rep_cnt_d = rep_cnt_q + REP_W'(1);
               end
            end
         end

         ARM_REL: begin
            if (s2_q) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               level_d = 1'b0;
               rel_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.btn_level = level_q;
   assign bus.btn_pulse = pulse_q;
   assign bus.btn_rel   = rel_q;

endmodule
